// File: rtl/btb_update_ctrl_if.sv
// Resolve-event queue and BTB write-port bundle for btb_update_ctrl.
// The execute/BTB side uses master, the controller uses slave.
interface btb_update_ctrl_if #(
  parameter int PC_W  = 6,
  parameter int IDX_W = 3
);
  logic              i_res_valid;
  logic              o_res_ready;
  logic [PC_W-1:0]   i_res_pc;
  logic [PC_W-1:0]   i_res_target;
  logic              i_res_taken;
  logic              i_res_fastcall;
  logic              i_res_fastz;
  logic              o_wr_en;
  logic [IDX_W-1:0]  o_wr_idx;
  logic [2*PC_W+2:0] o_wr_entry;
  logic              i_wr_stall;

  modport master (
    output i_res_valid, i_res_pc, i_res_target,
    output i_res_taken, i_res_fastcall, i_res_fastz,
    output i_wr_stall,
    input  o_res_ready, o_wr_en, o_wr_idx, o_wr_entry
  );

  modport slave (
    input  i_res_valid, i_res_pc, i_res_target,
    input  i_res_taken, i_res_fastcall, i_res_fastz,
    input  i_wr_stall,
    output o_res_ready, o_wr_en, o_wr_idx, o_wr_entry
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: classify resolved branches, issue writes, flush.
// Optional BTB_UPDATE_CTRL_STATS_EN adds alloc/evict/drop counters.
module btb_update_ctrl #(
  parameter int ENTRIES = 6,
  parameter int PC_W    = 6,
  parameter int QDEPTH  = 2,
  localparam int IDX_W  = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  btb_update_ctrl_if.slave bus,
  input  logic             i_flush_req,
  output logic             o_flush_busy,
  output logic [IDX_W-1:0] o_valid_count
`ifdef BTB_UPDATE_CTRL_STATS_EN
  ,
  output logic [7:0]       o_stat_alloc,
  output logic [7:0]       o_stat_evict,
  output logic [7:0]       o_stat_drop
`endif
);
  localparam int EW   = 2 * PC_W + 3;
  localparam int QP_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QC_W = $clog2(QDEPTH + 1);
  localparam logic [QC_W-1:0]  QFULL = QC_W'(QDEPTH);
  localparam logic [QP_W-1:0]  QLAST = QP_W'(QDEPTH - 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt;
    logic            taken;
    logic            fc;
    logic            fz;
  } ev_t;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t           state, state_n;
  ev_t              q_mem [QDEPTH];
  logic [QP_W-1:0]  wr_ptr, rd_ptr;
  logic [QC_W-1:0]  q_cnt;
  logic             push, pop, qclr;
  ev_t              head, ev_in;

  logic [ENTRIES-1:0] sh_valid;
  logic [PC_W-1:0]    sh_tag [ENTRIES];
  logic               sh_we, sh_clr;

  logic [IDX_W-1:0] rr_ptr, rr_n;
  logic             flush_pending, pend_n;
  logic             wr_en_q, wr_en_n;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_n;
  logic [EW-1:0]    wr_entry_q, wr_entry_n;

  logic             hit, full, wr_done, flush_last;
  logic [IDX_W-1:0] hit_idx, inv_idx;
  logic             tk_hit, tk_alloc, tk_evict, nt_hit, nt_miss;

  assign ev_in = '{pc: bus.i_res_pc, tgt: bus.i_res_target,
                   taken: bus.i_res_taken, fc: bus.i_res_fastcall,
                   fz: bus.i_res_fastz};
  assign head  = q_mem[rd_ptr];

  assign bus.o_res_ready = (q_cnt < QFULL) && (state != FLUSH)
                           && !flush_pending;
  assign push            = bus.i_res_valid && bus.o_res_ready;
  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_idx    = wr_idx_q;
  assign bus.o_wr_entry  = wr_entry_q;
  assign o_flush_busy    = flush_pending || (state == FLUSH);

  assign wr_done    = wr_en_q && !bus.i_wr_stall;
  assign flush_last = (state == FLUSH) && wr_done && (wr_idx_q == LAST);
  assign full       = &sh_valid;

  // Reverse scan so the lowest matching / invalid index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (sh_valid[i] && sh_tag[i] == head.pc) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!sh_valid[i]) inv_idx = IDX_W'(i);
    end
  end

  assign tk_hit   = head.taken && hit;
  assign tk_alloc = head.taken && !hit && !full;
  assign tk_evict = head.taken && !hit && full;
  assign nt_hit   = !head.taken && hit;
  assign nt_miss  = !head.taken && !hit;

  always_comb begin
    o_valid_count = '0;
    for (int i = 0; i < ENTRIES; i++)
      o_valid_count = o_valid_count + IDX_W'(sh_valid[i]);
  end

  always_comb begin
    state_n    = state;
    wr_en_n    = wr_en_q;
    wr_idx_n   = wr_idx_q;
    wr_entry_n = wr_entry_q;
    rr_n       = rr_ptr;
    pend_n     = flush_pending;
    pop        = 1'b0;
    qclr       = 1'b0;
    sh_we      = 1'b0;
    sh_clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_flush_req) begin
          state_n    = FLUSH;
          qclr       = 1'b1;
          wr_en_n    = 1'b1;
          wr_idx_n   = '0;
          wr_entry_n = '0;
        end else if (q_cnt != '0) begin
          pop        = 1'b1;
          wr_entry_n = {head.fz, head.fc, head.tgt, head.pc, 1'b1};
          unique case (1'b1)
            tk_hit: begin
              state_n  = ISSUE;
              wr_en_n  = 1'b1;
              wr_idx_n = hit_idx;
            end
            tk_alloc: begin
              state_n  = ISSUE;
              wr_en_n  = 1'b1;
              wr_idx_n = inv_idx;
            end
            tk_evict: begin
              state_n  = ISSUE;
              wr_en_n  = 1'b1;
              wr_idx_n = rr_ptr;
              rr_n     = (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
            end
            nt_hit: begin
              state_n    = ISSUE;
              wr_en_n    = 1'b1;
              wr_idx_n   = hit_idx;
              wr_entry_n = '0;
            end
            nt_miss: wr_entry_n = wr_entry_q;
          endcase
        end
      end
      ISSUE: begin
        if (i_flush_req) pend_n = 1'b1;
        if (wr_done) begin
          sh_we = 1'b1;
          if (flush_pending || i_flush_req) begin
            state_n    = FLUSH;
            pend_n     = 1'b0;
            qclr       = 1'b1;
            wr_idx_n   = '0;
            wr_entry_n = '0;
          end else begin
            state_n = IDLE;
            wr_en_n = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (flush_last) begin
          state_n = IDLE;
          wr_en_n = 1'b0;
          sh_clr  = 1'b1;
          rr_n    = '0;
        end else if (wr_done) begin
          wr_idx_n = wr_idx_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      flush_pending <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_idx_q      <= '0;
      wr_entry_q    <= '0;
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_n;
      flush_pending <= pend_n;
      wr_en_q       <= wr_en_n;
      wr_idx_q      <= wr_idx_n;
      wr_entry_q    <= wr_entry_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (qclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == QLAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == QLAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      q_cnt <= q_cnt + 1'b1;
      else if (!push && pop) q_cnt <= q_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= ev_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) sh_tag[i] <= '0;
    end else if (sh_clr) begin
      sh_valid <= '0;
    end else if (sh_we) begin
      sh_valid[wr_idx_q] <= wr_entry_q[0];
      sh_tag[wr_idx_q]   <= wr_entry_q[PC_W:1];
    end
  end

`ifdef BTB_UPDATE_CTRL_STATS_EN
  logic kind_alloc, kind_evict, iss_done;

  assign iss_done = (state == ISSUE) && wr_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_alloc   <= 1'b0;
      kind_evict   <= 1'b0;
      o_stat_alloc <= '0;
      o_stat_evict <= '0;
      o_stat_drop  <= '0;
    end else begin
      if (pop) begin
        kind_alloc <= tk_alloc;
        kind_evict <= tk_evict;
      end
      if (flush_last) begin
        o_stat_alloc <= '0;
        o_stat_evict <= '0;
        o_stat_drop  <= '0;
      end else begin
        if (pop && nt_miss && o_stat_drop != 8'hFF)
          o_stat_drop <= o_stat_drop + 1'b1;
        if (iss_done && kind_alloc && o_stat_alloc != 8'hFF)
          o_stat_alloc <= o_stat_alloc + 1'b1;
        if (iss_done && kind_evict && o_stat_evict != 8'hFF)
          o_stat_evict <= o_stat_evict + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: alloc/update/evict/invalidate,
// write stall, flush-in-issue and flush-in-idle.
module tb_btb_update_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush_req;
  logic       flush_busy;
  logic [2:0] valid_count;
`ifdef BTB_UPDATE_CTRL_STATS_EN
  logic [7:0] st_alloc, st_evict, st_drop;
`endif

  int total = 0;
  int bad   = 0;

  btb_update_ctrl_if #(.PC_W(6), .IDX_W(3)) bus ();

  btb_update_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .i_flush_req  (flush_req),
    .o_flush_busy (flush_busy),
    .o_valid_count(valid_count)
`ifdef BTB_UPDATE_CTRL_STATS_EN
    ,
    .o_stat_alloc (st_alloc),
    .o_stat_evict (st_evict),
    .o_stat_drop  (st_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] ent(input logic fz, input logic fc,
                                      input logic [5:0] tgt,
                                      input logic [5:0] pc);
    return {fz, fc, tgt, pc, 1'b1};
  endfunction

  task automatic drive(input logic [5:0] pc, input logic [5:0] tgt,
                       input logic tk, input logic fc, input logic fz);
    bus.i_res_valid    = 1'b1;
    bus.i_res_pc       = pc;
    bus.i_res_target   = tgt;
    bus.i_res_taken    = tk;
    bus.i_res_fastcall = fc;
    bus.i_res_fastz    = fz;
  endtask

  task automatic do_ev(input string tag, input logic [5:0] pc,
                       input logic [5:0] tgt, input logic tk,
                       input logic fc, input logic fz, input logic ew,
                       input logic [2:0] ei, input logic [14:0] ee);
    chk({tag, "_rdy"}, bus.o_res_ready, 1);
    drive(pc, tgt, tk, fc, fz);
    tick();
    bus.i_res_valid = 1'b0;
    chk({tag, "_lat"}, bus.o_wr_en, 0);
    tick();
    chk({tag, "_en"}, bus.o_wr_en, ew);
    if (ew) begin
      chk({tag, "_idx"}, bus.o_wr_idx, ei);
      chk({tag, "_ent"}, bus.o_wr_entry, ee);
      tick();
      chk({tag, "_done"}, bus.o_wr_en, 0);
    end
  endtask

  task automatic flush_seq(input string tag, input int poke_at);
    for (int k = 0; k < 6; k++) begin
      chk({tag, "_en"}, bus.o_wr_en, 1);
      chk({tag, "_idx"}, bus.o_wr_idx, k);
      chk({tag, "_ent"}, bus.o_wr_entry, 0);
      chk({tag, "_busy"}, flush_busy, 1);
      flush_req = (k == poke_at);
      tick();
      flush_req = 1'b0;
    end
    chk({tag, "_end_en"}, bus.o_wr_en, 0);
    chk({tag, "_end_busy"}, flush_busy, 0);
    chk({tag, "_end_cnt"}, valid_count, 0);
    chk({tag, "_end_rdy"}, bus.o_res_ready, 1);
  endtask

  initial begin
    reset_n     = 1'b0;
    flush_req   = 1'b0;
    bus.i_wr_stall = 1'b0;
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    bus.i_res_valid = 1'b0;
    repeat (2) tick();
    chk("rst_rdy", bus.o_res_ready, 1);
    chk("rst_en", bus.o_wr_en, 0);
    chk("rst_idx", bus.o_wr_idx, 0);
    chk("rst_ent", bus.o_wr_entry, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_cnt", valid_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    do_ev("alloc0", 6'h05, 6'h20, 1, 0, 0, 1, 3'd0, ent(0, 0, 6'h20, 6'h05));
    chk("alloc0_cnt", valid_count, 1);
    do_ev("upd0", 6'h05, 6'h31, 1, 0, 1, 1, 3'd0, ent(1, 0, 6'h31, 6'h05));
    chk("upd0_cnt", valid_count, 1);

    for (int i = 1; i < 6; i++)
      do_ev("fill", 6'(6'h10 + i), 6'(i), 1, 0, 0, 1, 3'(i),
            ent(0, 0, 6'(i), 6'(6'h10 + i)));
    chk("fill_cnt", valid_count, 6);
    do_ev("evict0", 6'h3A, 6'h0A, 1, 1, 0, 1, 3'd0, ent(0, 1, 6'h0A, 6'h3A));
    do_ev("evict1", 6'h3B, 6'h0B, 1, 0, 0, 1, 3'd1, ent(0, 0, 6'h0B, 6'h3B));
    chk("evict_cnt", valid_count, 6);

    do_ev("inval", 6'h13, 6'h00, 0, 0, 0, 1, 3'd3, 15'h0);
    chk("inval_cnt", valid_count, 5);
    do_ev("drop", 6'h11, 6'h00, 0, 0, 0, 0, 3'd0, 15'h0);
    chk("drop_cnt", valid_count, 5);
    do_ev("refill", 6'h20, 6'h2F, 1, 0, 0, 1, 3'd3, ent(0, 0, 6'h2F, 6'h20));
    chk("refill_cnt", valid_count, 6);

    bus.i_wr_stall = 1'b1;
    drive(6'h21, 6'h01, 1, 0, 0);
    tick();
    drive(6'h22, 6'h02, 1, 0, 0);
    tick();
    chk("stl_en0", bus.o_wr_en, 1);
    chk("stl_idx0", bus.o_wr_idx, 2);
    chk("stl_ent0", bus.o_wr_entry, ent(0, 0, 6'h01, 6'h21));
    drive(6'h23, 6'h03, 1, 0, 0);
    tick();
    bus.i_res_valid = 1'b0;
    chk("stl_rdy", bus.o_res_ready, 0);
    chk("stl_idx1", bus.o_wr_idx, 2);
    chk("stl_ent1", bus.o_wr_entry, ent(0, 0, 6'h01, 6'h21));
    tick();
    chk("stl_en2", bus.o_wr_en, 1);
    chk("stl_idx2", bus.o_wr_idx, 2);
    chk("stl_ent2", bus.o_wr_entry, ent(0, 0, 6'h01, 6'h21));
    bus.i_wr_stall = 1'b0;
    tick();
    chk("stl_done", bus.o_wr_en, 0);
    chk("stl_rdy2", bus.o_res_ready, 0);
    tick();
    chk("fi_en", bus.o_wr_en, 1);
    chk("fi_idx", bus.o_wr_idx, 3);
    chk("fi_ent", bus.o_wr_entry, ent(0, 0, 6'h02, 6'h22));
    bus.i_wr_stall = 1'b1;
    drive(6'h24, 6'h04, 1, 0, 0);
    tick();
    bus.i_res_valid = 1'b0;
    chk("fi_rdy", bus.o_res_ready, 0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("fi_busy", flush_busy, 1);
    chk("fi_hold", bus.o_wr_idx, 3);
    chk("fi_rdy2", bus.o_res_ready, 0);
    bus.i_wr_stall = 1'b0;
    tick();
    flush_seq("fl1", -1);
    tick();
    chk("fl1_noq", bus.o_wr_en, 0);

    for (int i = 0; i < 6; i++)
      do_ev("fill2", 6'(6'h30 + i), 6'h15, 1, 0, 0, 1, 3'(i),
            ent(0, 0, 6'h15, 6'(6'h30 + i)));
    do_ev("rr0", 6'h36, 6'h16, 1, 0, 0, 1, 3'd0, ent(0, 0, 6'h16, 6'h36));

    drive(6'h37, 6'h17, 1, 0, 0);
    flush_req = 1'b1;
    tick();
    bus.i_res_valid = 1'b0;
    flush_req = 1'b0;
    flush_seq("fl2", 2);
    tick();
    chk("fl2_q1", bus.o_wr_en, 0);
    tick();
    chk("fl2_q2", bus.o_wr_en, 0);
    chk("fl2_busy", flush_busy, 0);
    chk("fl2_cnt", valid_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
